// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: defaults, FSM encoding
// and the buffered {pc, inst} entry type.
package fetch_unit_pkg;

  localparam logic [31:0] NopInst        = 32'h0000_0013;
  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StDrain = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/ack bus between the fetch unit and its memory.
interface fetch_unit_if;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_rdata_i
  );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {pc, inst} pairs; flush wins over push and pop.
module fetch_buffer
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = push_entry_i;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding imem requests, redirect/drain
// handling and a two-entry buffer feeding the IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc,
  parameter logic [31:0] NOP_INST = NopInst
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                stall_i,
  input  logic                redirect_i,
  input  logic [31:0]         redirect_pc_i,
  fetch_unit_if.master        imem,
  output logic [31:0]         inst_o,
  output logic [31:0]         pc_o,
  output logic [31:0]         pcPlus4_o,
  output logic                valid_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  target_q, target_d;

  logic         done;
  logic         push;
  logic         pop;
  logic [1:0]   count;
  logic [1:0]   count_after;
  logic [31:0]  redirect_pc;
  fetch_entry_t head;
  fetch_entry_t push_entry;

  assign imem.imem_req_o  = (state_q != StIdle);
  assign imem.imem_addr_o = fetch_pc_q;

  // A late ack while no request is driven must not count as a completion.
  assign done        = imem.imem_req_o && imem.imem_ack_i;
  assign redirect_pc = align_pc(redirect_pc_i);
  assign valid_o     = (count != 2'd0) && !redirect_i;
  assign pop         = valid_o && !stall_i;
  assign push        = (state_q == StFetch) && done && !redirect_i;
  assign count_after = count + {1'b0, push} - {1'b0, pop};
  assign push_entry  = '{pc: fetch_pc_q, inst: imem.imem_rdata_i};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    target_d   = target_q;
    unique case (state_q)
      StIdle: begin
        if (redirect_i) begin
          fetch_pc_d = redirect_pc;
        end else if (count < 2'd2) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (redirect_i) begin
          if (done) begin
            fetch_pc_d = redirect_pc;
          end else begin
            state_d  = StDrain;
            target_d = redirect_pc;
          end
        end else if (done) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          if (count_after == 2'd2) begin
            state_d = StIdle;
          end
        end
      end
      StDrain: begin
        // Address stays on the abandoned fetch until its response is swallowed.
        if (done) begin
          state_d    = StFetch;
          fetch_pc_d = redirect_i ? redirect_pc : target_q;
        end else if (redirect_i) begin
          target_d = redirect_pc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      target_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      target_q   <= target_d;
    end
  end

  fetch_buffer u_fetch_buffer (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush_i      (redirect_i),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .count_o      (count),
    .head_o       (head)
  );

  always_comb begin
    inst_o    = NOP_INST;
    pc_o      = 32'd0;
    pcPlus4_o = 32'd0;
    if (count != 2'd0) begin
      inst_o    = head.inst;
      pc_o      = head.pc;
      pcPlus4_o = head.pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirect/drain, wrap and reset.
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic [31:0] inst1, pc1, pc41;
  logic        valid1;
  logic [31:0] inst2, pc2, pc42;
  logic        valid2;

  int tests_run;
  int tests_failed;

  fetch_unit_if imem1 ();
  fetch_unit_if imem2 ();

  // Memory model: each word is its address plus a fixed tag.
  assign imem1.imem_rdata_i = imem1.imem_addr_o + 32'h1000_0000;
  assign imem2.imem_rdata_i = imem2.imem_addr_o + 32'h1000_0000;
  assign imem2.imem_ack_i   = 1'b1;

  fetch_unit u_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem          (imem1),
    .inst_o        (inst1),
    .pc_o          (pc1),
    .pcPlus4_o     (pc41),
    .valid_o       (valid1)
  );

  fetch_unit #(
    .RESET_PC (32'hFFFF_FFF8)
  ) u_dut_wrap (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall_i       (1'b0),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'd0),
    .imem          (imem2),
    .inst_o        (inst2),
    .pc_o          (pc2),
    .pcPlus4_o     (pc42),
    .valid_o       (valid2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    stall        = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 32'd0;
    imem1.imem_ack_i = 1'b0;

    nxt();
    chk("rst_req",   {31'd0, imem1.imem_req_o}, 32'd0);
    chk("rst_addr",  imem1.imem_addr_o, 32'd0);
    chk("rst_valid", {31'd0, valid1}, 32'd0);
    chk("rst_inst",  inst1, 32'h0000_0013);
    chk("rst_pc",    pc1, 32'd0);
    chk("rst_pc4",   pc41, 32'd0);
    chk("rst_addr_wrap", imem2.imem_addr_o, 32'hFFFF_FFF8);

    // Release reset, zero-wait memory.
    reset_n = 1'b1;
    imem1.imem_ack_i = 1'b1;
    #1;
    chk("rel_req", {31'd0, imem1.imem_req_o}, 32'd0);
    nxt();
    chk("c1_req",   {31'd0, imem1.imem_req_o}, 32'd1);
    chk("c1_addr",  imem1.imem_addr_o, 32'd0);
    chk("c1_valid", {31'd0, valid1}, 32'd0);
    nxt();
    chk("c2_valid", {31'd0, valid1}, 32'd1);
    chk("c2_pc",    pc1, 32'h0);
    chk("c2_inst",  inst1, 32'h1000_0000);
    chk("c2_pc4",   pc41, 32'h4);
    chk("wrap_pc0", pc2, 32'hFFFF_FFF8);
    chk("wrap_v0",  {31'd0, valid2}, 32'd1);
    nxt();
    chk("c3_pc",    pc1, 32'h4);
    chk("wrap_pc1", pc2, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc42, 32'h0);
    nxt();
    chk("c4_pc",    pc1, 32'h8);
    chk("wrap_pc2", pc2, 32'h0);
    nxt();
    chk("c5_pc",    pc1, 32'hC);
    chk("c5_valid", {31'd0, valid1}, 32'd1);

    // Stall for four cycles: buffer fills to two and requests stop.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("stall_req",   {31'd0, imem1.imem_req_o}, 32'd0);
      chk("stall_pc",    pc1, 32'hC);
      chk("stall_valid", {31'd0, valid1}, 32'd1);
    end
    nxt();
    stall = 1'b0;
    #1;
    chk("unstall_pc", pc1, 32'hC);
    nxt();
    chk("resume_pc",  pc1, 32'h10);
    chk("resume_req", {31'd0, imem1.imem_req_o}, 32'd0);
    nxt();
    chk("refill_req",  {31'd0, imem1.imem_req_o}, 32'd1);
    chk("refill_addr", imem1.imem_addr_o, 32'h14);
    chk("refill_valid", {31'd0, valid1}, 32'd0);
    nxt();
    chk("refill_pc", pc1, 32'h14);

    // Redirect to 0x102 while the fetch of 0x18 is pending.
    imem1.imem_ack_i = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    #1;
    chk("redir_valid_comb", {31'd0, valid1}, 32'd0);
    nxt();
    redirect = 1'b0;
    #1;
    chk("drain_valid", {31'd0, valid1}, 32'd0);
    chk("drain_req",   {31'd0, imem1.imem_req_o}, 32'd1);
    chk("drain_addr",  imem1.imem_addr_o, 32'h18);
    nxt();
    chk("drain2_addr", imem1.imem_addr_o, 32'h18);
    nxt();
    imem1.imem_ack_i = 1'b1;
    #1;
    chk("drain3_addr",  imem1.imem_addr_o, 32'h18);
    chk("drain3_valid", {31'd0, valid1}, 32'd0);
    nxt();
    chk("tgt_addr",  imem1.imem_addr_o, 32'h100);
    chk("tgt_valid", {31'd0, valid1}, 32'd0);
    nxt();
    chk("tgt_pc",   pc1, 32'h100);
    chk("tgt_inst", inst1, 32'h1000_0100);

    // Two redirects during drain: only the newest target is fetched.
    imem1.imem_ack_i = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    #1;
    chk("dbl_valid", {31'd0, valid1}, 32'd0);
    nxt();
    redirect_pc = 32'h300;
    #1;
    chk("dbl_addr_hold", imem1.imem_addr_o, 32'h104);
    nxt();
    redirect = 1'b0;
    imem1.imem_ack_i = 1'b1;
    #1;
    chk("dbl_addr_hold2", imem1.imem_addr_o, 32'h104);
    nxt();
    chk("dbl_addr", imem1.imem_addr_o, 32'h300);
    chk("dbl_valid2", {31'd0, valid1}, 32'd0);
    nxt();
    chk("dbl_pc",   pc1, 32'h300);
    chk("dbl_inst", inst1, 32'h1000_0300);

    // Redirect coincident with ack: data dropped, no drain.
    redirect    = 1'b1;
    redirect_pc = 32'h403;
    #1;
    chk("coin_valid", {31'd0, valid1}, 32'd0);
    nxt();
    redirect = 1'b0;
    #1;
    chk("coin_addr",  imem1.imem_addr_o, 32'h400);
    chk("coin_req",   {31'd0, imem1.imem_req_o}, 32'd1);
    chk("coin_valid2", {31'd0, valid1}, 32'd0);
    nxt();
    chk("coin_pc", pc1, 32'h400);
    imem1.imem_ack_i = 1'b0;

    // Reset in the middle of a pending fetch, then a late ack.
    nxt();
    chk("pre_rst_addr", imem1.imem_addr_o, 32'h404);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req",   {31'd0, imem1.imem_req_o}, 32'd0);
    chk("mid_rst_addr",  imem1.imem_addr_o, 32'd0);
    chk("mid_rst_valid", {31'd0, valid1}, 32'd0);
    chk("mid_rst_inst",  inst1, 32'h0000_0013);
    chk("mid_rst_pc",    pc1, 32'd0);
    chk("mid_rst_pc4",   pc41, 32'd0);
    nxt();
    reset_n = 1'b1;
    imem1.imem_ack_i = 1'b1;
    #1;
    chk("late_ack_req",   {31'd0, imem1.imem_req_o}, 32'd0);
    chk("late_ack_valid", {31'd0, valid1}, 32'd0);
    nxt();
    chk("restart_addr",  imem1.imem_addr_o, 32'd0);
    chk("restart_req",   {31'd0, imem1.imem_req_o}, 32'd1);
    chk("restart_valid", {31'd0, valid1}, 32'd0);
    nxt();
    chk("restart_pc",    pc1, 32'd0);
    chk("restart_valid2", {31'd0, valid1}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), instruction driven when no valid instruction is held.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 stall_i  input  1  downstream IF/ID hold; head instruction not consumed.
REQ-006 redirect_i  input  1  taken branch/jump; flush and refetch.
REQ-007 redirect_pc_i  input  32  redirect target.
REQ-008 imem_req_o  output  1  instruction memory request.
REQ-009 imem_addr_o  output  32  request address, word aligned.
REQ-010 imem_ack_i  input  1  memory completes request this cycle.
REQ-011 imem_rdata_i  input  32  instruction word, valid with imem_ack_i.
REQ-012 inst_o  output  32  head instruction to IF/ID register.
REQ-013 pc_o  output  32  PC of inst_o.
REQ-014 pcPlus4_o  output  32  pc_o + 4.
REQ-015 valid_o  output  1  inst_o/pc_o/pcPlus4_o hold a live instruction.

Function
REQ-016 Transaction completes in any cycle with imem_req_o && imem_ack_i; ack in the first request cycle SHALL be accepted (zero-wait memory).
REQ-017 imem_req_o and imem_addr_o SHALL stay constant from assertion until completion; at most one transaction outstanding.
REQ-018 FSM states IDLE (no request), FETCH (request active), DRAIN (request active, response to be discarded).
REQ-019 IDLE->FETCH when buffer count < 2 and no redirect this cycle; FETCH->IDLE on completion if count after enqueue = 2, else remain FETCH with fetch_pc+4.
REQ-020 FETCH->DRAIN on redirect_i without same-cycle ack; DRAIN->FETCH on completion, addressing the stored redirect target; response data discarded.
REQ-021 Redirect in DRAIN SHALL overwrite the stored target; only the newest target is fetched.
REQ-022 Redirect coincident with ack SHALL discard that data and request redirect_pc_i next cycle, no DRAIN.
REQ-023 Redirect target bits [1:0] SHALL be forced to 0; fetch_pc increments modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 Two-entry FIFO of {pc, inst}; enqueue on completion in FETCH only; dequeue when valid_o && !stall_i; simultaneous enqueue/dequeue at count 2 impossible by REQ-019, at count 1 keeps count 1.
REQ-025 redirect_i SHALL clear the FIFO at the clock edge, overriding enqueue and dequeue; valid_o SHALL be 0 combinationally in the redirect cycle.
REQ-026 valid_o = (count != 0) && !redirect_i; when count = 0 outputs inst_o = NOP_INST, pc_o = 0, pcPlus4_o = 0.
REQ-027 Latency: first imem_req_o in the first cycle after reset release; zero-wait ack gives valid_o the following cycle; sustained throughput one instruction per cycle with zero-wait memory and no stall.

Reset
REQ-028 Reset SHALL asynchronously set state IDLE, fetch_pc RESET_PC, FIFO count 0, stored target 0, imem_req_o 0, imem_addr_o RESET_PC, valid_o 0, inst_o NOP_INST, pc_o 0, pcPlus4_o 0.
REQ-029 Reset mid-transaction SHALL abandon the request; a late ack after reset release while imem_req_o = 0 SHALL be ignored.

Structure
REQ-030 Shared package holds NOP_INST, default RESET_PC, and FSM state encoding.
REQ-031 Sub-module fetch_buffer implements the 2-entry {pc, inst} FIFO with flush, push, pop, count.

Verification
REQ-032 Reset release, zero-wait ack every cycle, no stall -> pc_o 0,4,8,C on consecutive cycles, valid_o continuous from cycle 2.
REQ-033 stall_i held 4 cycles -> at most 2 entries buffered, imem_req_o drops, pc_o frozen; release -> ordered resume, no loss/duplicate.
REQ-034 Redirect to 32'h0000_0102 while ack pending 3 cycles -> old data discarded, next request addr 32'h0000_0100, valid_o 0 until its return.
REQ-035 Two redirects (0x200 then 0x300) during DRAIN -> only 0x300 fetched.
REQ-036 RESET_PC = 32'hFFFF_FFF8 -> fetch sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, pcPlus4_o of FFFF_FFFC = 0.
REQ-037 reset_n pulsed low mid-FETCH with late ack -> outputs at reset values, fetch restarts at RESET_PC.
